program_loader: RTL

Program loader sitting directly upstream of `cpu_top`'s program memory. Holds the CPU in reset, fills all 256 memory bytes with a NOP fill value, then receives a length-prefixed, checksummed byte stream over a valid/ready interface and writes the payload into memory. It releases the CPU on a good checksum. It is the synthesizable replacement for loading memory from a file in simulation.

---
 rtl/program_loader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader
//   Sits in front of the CPU program memory. After reset (or restart) it holds
//   the CPU in reset and fills all 256 bytes with FILL_BYTE. It then takes a
//   byte stream of the form [N][payload x N][checksum] over valid/ready, where
//   N=0 means 256. Payload byte k is written to LOAD_BASE+k (mod 256). The CPU
//   is released only if the checksum equals the 8-bit sum of the payload.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   restart      single-cycle pulse, honoured only in DONE / ERROR
//   rx_valid     upstream byte valid
//   rx_data      upstream byte
//   rx_ready     loader accepts rx_data this cycle (decoded from state)
//   mem_we       memory write strobe (registered)
//   mem_addr     memory write address (registered)
//   mem_wdata    memory write data (registered)
//   cpu_reset    active-high reset to the CPU (registered)
//   load_done    high in DONE (registered)
//   load_error   high in ERROR (registered)
//   bytes_loaded payload bytes written in the current load, 0..256 (registered)
module program_loader #(
  parameter logic [7:0] LOAD_BASE = 8'h00,
  parameter logic [7:0] FILL_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_reset,
  output logic       load_done,
  output logic       load_error,
  output logic [8:0] bytes_loaded
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_WAIT_LEN,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t     r_state;
  logic [8:0] r_clr_cnt;   // bit 8 set once address 255 has been issued
  logic [8:0] r_len;
  logic [7:0] r_sum;
  logic       r_mem_we;
  logic [7:0] r_mem_addr;
  logic [7:0] r_mem_wdata;
  logic       r_cpu_reset;
  logic       r_load_done;
  logic       r_load_error;
  logic [8:0] r_bytes_loaded;

  state_t     w_state_nxt;
  logic [8:0] w_clr_cnt_nxt;
  logic [8:0] w_len_nxt;
  logic [7:0] w_sum_nxt;
  logic       w_mem_we_nxt;
  logic [7:0] w_mem_addr_nxt;
  logic [7:0] w_mem_wdata_nxt;
  logic       w_cpu_reset_nxt;
  logic       w_load_done_nxt;
  logic       w_load_error_nxt;
  logic [8:0] w_bytes_loaded_nxt;
  logic       w_accept;

  function automatic logic [7:0] f_load_addr(input logic [8:0] idx);
    return LOAD_BASE + idx[7:0];
  endfunction

  function automatic logic [7:0] f_sum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  assign rx_ready = (r_state == S_WAIT_LEN) || (r_state == S_LOAD) || (r_state == S_CHECK);
  assign w_accept = rx_valid && rx_ready;

  always_comb begin
    w_state_nxt        = r_state;
    w_clr_cnt_nxt      = r_clr_cnt;
    w_len_nxt          = r_len;
    w_sum_nxt          = r_sum;
    w_mem_we_nxt       = 1'b0;
    w_mem_addr_nxt     = r_mem_addr;
    w_mem_wdata_nxt    = r_mem_wdata;
    w_cpu_reset_nxt    = r_cpu_reset;
    w_load_done_nxt    = r_load_done;
    w_load_error_nxt   = r_load_error;
    w_bytes_loaded_nxt = r_bytes_loaded;

    case (r_state)
      S_CLEAR: begin
        // One extra cycle after the address-255 write so rx_ready rises only
        // once the last fill write is on the bus.
        if (!r_clr_cnt[8]) begin
          w_mem_we_nxt    = 1'b1;
          w_mem_addr_nxt  = r_clr_cnt[7:0];
          w_mem_wdata_nxt = FILL_BYTE;
          w_clr_cnt_nxt   = r_clr_cnt + 9'd1;
        end else begin
          w_state_nxt = S_WAIT_LEN;
        end
      end
      S_WAIT_LEN: begin
        if (w_accept) begin
          w_len_nxt          = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          w_bytes_loaded_nxt = 9'd0;
          w_sum_nxt          = 8'h00;
          w_state_nxt        = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_mem_we_nxt       = 1'b1;
          w_mem_addr_nxt     = f_load_addr(r_bytes_loaded);
          w_mem_wdata_nxt    = rx_data;
          w_sum_nxt          = f_sum_add(r_sum, rx_data);
          w_bytes_loaded_nxt = r_bytes_loaded + 9'd1;
          if (w_bytes_loaded_nxt == r_len) begin
            w_state_nxt = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (w_accept) begin
          if (rx_data == r_sum) begin
            w_state_nxt     = S_DONE;
            w_cpu_reset_nxt = 1'b0;
            w_load_done_nxt = 1'b1;
          end else begin
            w_state_nxt      = S_ERROR;
            w_load_error_nxt = 1'b1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        // Restart issues the address-0 fill write immediately so the clear
        // begins in the cycle right after the restart edge.
        if (restart) begin
          w_state_nxt        = S_CLEAR;
          w_cpu_reset_nxt    = 1'b1;
          w_load_done_nxt    = 1'b0;
          w_load_error_nxt   = 1'b0;
          w_bytes_loaded_nxt = 9'd0;
          w_mem_we_nxt       = 1'b1;
          w_mem_addr_nxt     = 8'h00;
          w_mem_wdata_nxt    = FILL_BYTE;
          w_clr_cnt_nxt      = 9'd1;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_CLEAR;
      r_clr_cnt      <= 9'd0;
      r_len          <= 9'd0;
      r_sum          <= 8'h00;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= 8'h00;
      r_mem_wdata    <= 8'h00;
      r_cpu_reset    <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
      r_bytes_loaded <= 9'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_clr_cnt      <= w_clr_cnt_nxt;
      r_len          <= w_len_nxt;
      r_sum          <= w_sum_nxt;
      r_mem_we       <= w_mem_we_nxt;
      r_mem_addr     <= w_mem_addr_nxt;
      r_mem_wdata    <= w_mem_wdata_nxt;
      r_cpu_reset    <= w_cpu_reset_nxt;
      r_load_done    <= w_load_done_nxt;
      r_load_error   <= w_load_error_nxt;
      r_bytes_loaded <= w_bytes_loaded_nxt;
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_reset    = r_cpu_reset;
  assign load_done    = r_load_done;
  assign load_error   = r_load_error;
  assign bytes_loaded = r_bytes_loaded;

endmodule
